// File: rtl/comparator_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comparator_arbiter: 4-way round-robin arbiter feeding an N-bit equality   |
// | comparator, with response handshake and completion/match counters.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module comparator_arbiter_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_eq
);
  logic [N-1:0] w_bit;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign w_bit[gi] = ~(i_a[gi] ^ i_b[gi]);
  end

  assign o_eq = &w_bit;
endmodule

module comparator_arbiter #(
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic           resp_valid,
  output logic [1:0]     resp_id,
  output logic           resp_eq,
  input  logic           resp_ready,
  output logic           busy,
  output logic [15:0]    total_count,
  output logic [15:0]    match_count
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   w_next;
  logic [1:0]   r_ptr;
  logic [1:0]   r_id;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic         r_eq;
  logic [15:0]  r_total;
  logic [15:0]  r_match;

  logic [2*R-1:0] w_dbl;
  logic [R-1:0]   w_rot;
  logic [1:0]     w_off;
  logic [1:0]     w_gidx;
  logic           w_any;
  logic           w_take;
  logic           w_done;
  logic           w_eq;
  logic [N-1:0]   w_sel_a;
  logic [N-1:0]   w_sel_b;

  // Rotate the request vector so bit 0 is the requester at the pointer.
  assign w_dbl = {req_valid, req_valid};
  assign w_rot = w_dbl[r_ptr +: R];

  always_comb begin
    w_any = 1'b0;
    w_off = 2'd0;
    for (int k = R - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_off = 2'(k);
      end
    end
  end

  assign w_gidx  = r_ptr + w_off;
  assign w_take  = (r_state == S_IDLE) && w_any && !rst;
  assign w_done  = (r_state == S_RESP) && resp_ready;
  assign w_sel_a = req_a[int'(w_gidx)*N +: N];
  assign w_sel_b = req_b[int'(w_gidx)*N +: N];

  comparator_arbiter_eq #(.N(N)) u_eq (
    .i_a  (r_a),
    .i_b  (r_b),
    .o_eq (w_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_CMP;
      S_CMP:   w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = (r_state == S_RESP);
    busy       = (r_state != S_IDLE);
    if (w_take) begin
      req_ready = R'(1) << w_gidx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= 2'd0;
      r_id    <= 2'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_eq    <= 1'b0;
      r_total <= 16'd0;
      r_match <= 16'd0;
    end else begin
      if (w_take) begin
        r_a  <= w_sel_a;
        r_b  <= w_sel_b;
        r_id <= w_gidx;
      end
      if (r_state == S_CMP) begin
        r_eq <= w_eq;
      end
      if (w_done) begin
        r_ptr   <= r_id + 2'd1;
        r_total <= r_total + 16'd1;
        if (r_eq) begin
          r_match <= r_match + 16'd1;
        end
      end
    end
  end

  assign resp_id     = r_id;
  assign resp_eq     = r_eq;
  assign total_count = r_total;
  assign match_count = r_match;
endmodule

`default_nettype wire
